branch_direction_predictor: RTL



---
 rtl/bp_pkg.sv | 28 ++
 rtl/sat_counter2.sv | 34 +++
 rtl/branch_direction_predictor.sv | 89 ++++++++
 3 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and constants for the branch prediction tables.
//               BP_LOWER is also used by the branch target buffer so that both
//               tables are indexed with the same number of PC bits.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Default index width shared by the direction table and the target buffer
    localparam int unsigned BP_LOWER = 5;

    // 2-bit saturating direction counter; the MSB is the taken prediction
    typedef logic [1:0] cnt2_t;

    localparam cnt2_t CNT_SNT = 2'd0;   // strongly not-taken
    localparam cnt2_t CNT_WNT = 2'd1;   // weakly not-taken
    localparam cnt2_t CNT_WT  = 2'd2;   // weakly taken
    localparam cnt2_t CNT_ST  = 2'd3;   // strongly taken

    // Direction implied by a counter value
    function automatic logic cnt_predicts_taken(input cnt2_t c);
        return c[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Combinational next-value function of a 2-bit saturating
//               counter. Counts up on taken, down on not-taken, and sticks at
//               the strong ends of the range.
// Ports       : cur   - present counter value
//               taken - resolved branch direction (1 = taken)
//               nxt   - counter value after training
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CNT_ST) begin
                nxt = cur + 2'd1;
            end
        end else begin
            if (cur != CNT_SNT) begin
                nxt = cur - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_direction_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_direction_predictor
// Description : Gshare direction predictor for the fetch stage. A table of
//               2**LOWER 2-bit saturating counters is indexed by the low PC
//               bits XOR a non-speculative global history register. The
//               prediction is registered, giving the same 1-cycle latency as
//               the branch target buffer lookup.
// Ports       : clk        - clock, all state changes on the rising edge
//               rst        - synchronous active-high reset
//               en         - fetch advance; loads the prediction registers
//               current_pc - PC being fetched this cycle
//               upd_valid  - resolved conditional branch from execute
//               upd_index  - table index returned from the original lookup
//               upd_taken  - resolved direction
//               pred_taken - registered prediction (1 = taken)
//               pred_index - registered index behind pred_taken
// Revision    : 1.0 - initial release
// ============================================================================
module branch_direction_predictor
    import bp_pkg::*;
#(
    parameter int unsigned LOWER    = BP_LOWER,
    parameter logic [1:0]  CNT_INIT = CNT_WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [63:0]      current_pc,
    input  logic             upd_valid,
    input  logic [LOWER-1:0] upd_index,
    input  logic             upd_taken,
    output logic             pred_taken,
    output logic [LOWER-1:0] pred_index
);

    localparam int unsigned DEPTH = 1 << LOWER;

    cnt2_t            r_cnt [DEPTH];
    logic [LOWER-1:0] r_ghr;
    logic             r_pred_taken;
    logic [LOWER-1:0] r_pred_index;

    logic [LOWER-1:0] w_idx;
    cnt2_t            w_upd_cur;
    cnt2_t            w_upd_nxt;
    logic             w_unused_pc_bits;

    // Only the low PC bits take part in the hash
    assign w_unused_pc_bits = ^current_pc[63:LOWER];

    // Lookup always hashes with the history as it stands before this cycle's
    // update, so a same-cycle resolution never affects the current lookup.
    assign w_idx     = current_pc[LOWER-1:0] ^ r_ghr;
    assign w_upd_cur = r_cnt[upd_index];

    sat_counter2 u_sat_counter2 (
        .cur   (w_upd_cur),
        .taken (upd_taken),
        .nxt   (w_upd_nxt)
    );

    // Reading r_cnt and writing it with non-blocking assignments in the same
    // block gives read-before-write behaviour on an index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= CNT_INIT;
            end
            r_ghr        <= '0;
            r_pred_taken <= 1'b0;
            r_pred_index <= '0;
        end else begin
            if (en) begin
                r_pred_index <= w_idx;
                r_pred_taken <= cnt_predicts_taken(r_cnt[w_idx]);
            end
            if (upd_valid) begin
                r_cnt[upd_index] <= w_upd_nxt;
                r_ghr            <= {r_ghr[LOWER-2:0], upd_taken};
            end
        end
    end

    assign pred_taken = r_pred_taken;
    assign pred_index = r_pred_index;

endmodule
`default_nettype wire
